mem_stage_ws: RTL and testbench

- Memory stage of the simple pipelined ARM core. Sits directly downstream of the Execute/Memory pipeline register and consumes its ALU result, write data, destination register and PC outputs.
- Contains a word-addressed data RAM with a configurable number of wait states, plus the Memory/Writeback pipeline register.
- While a multi-cycle access is in progress, asserts StallM so the upstream pipeline registers hold; their write enable is driven by ~StallM.

---
 rtl/mem_stage_ws.sv | 114 +++++++++++
 tb/tb_mem_stage_ws.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// Memory stage of the pipelined ARM core: word-addressed data RAM with a
// configurable number of wait states, followed by the Memory/Writeback register.
module mem_stage_ws #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  input  logic [31:0] PCM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic [31:0] PCW,
  output logic        RegWriteW,
  output logic        MemtoRegW
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic                 memop, is_store, is_load;
  logic                 stall, bubble, complete, ram_we;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          ram [2**ADDR_BITS];

  // A store wins when both flags are set; address low bits and upper bits are dropped.
  assign memop    = MemtoRegM | MemWriteM;
  assign is_store = MemWriteM;
  assign is_load  = MemtoRegM & ~MemWriteM;
  assign idx      = ALUResultM[ADDR_BITS+1:2];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    bubble     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            stall      = 1'b1;
            bubble     = 1'b1;
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          stall    = 1'b1;
          bubble   = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign StallM = stall & reset;
  assign ram_we = complete & is_store & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= WriteDataM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WA3W      <= '0;
      PCW       <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else if (bubble) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      ReadDataW <= is_load ? ram[idx] : '0;
      ALUOutW   <= ALUResultM;
      WA3W      <= WA3M;
      PCW       <= PCM;
      RegWriteW <= RegWriteM;
      MemtoRegW <= is_load;
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: a 2-wait-state instance and a 0-wait-state instance,
// checked against a word-array memory model and an expected writeback record.
module tb_mem_stage_ws;

  localparam int AB    = 6;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  wa3;
    logic [31:0] pc;
    logic        rw;
    logic        mtr;
    logic        mw;
  } op_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [3:0]  wa3;
    logic        rw;
    logic        mtr;
    bit          rd_known;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  op_t in_a, in_b;
  logic        a_stall, b_stall;
  logic [31:0] a_rd, b_rd, a_alu, b_alu, a_pc, b_pc;
  logic [3:0]  a_wa3, b_wa3;
  logic        a_rw, b_rw, a_mtr, b_mtr;

  mem_stage_ws #(.ADDR_BITS(AB), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(in_a.alu), .WriteDataM(in_a.wd), .WA3M(in_a.wa3), .PCM(in_a.pc),
    .RegWriteM(in_a.rw), .MemtoRegM(in_a.mtr), .MemWriteM(in_a.mw),
    .StallM(a_stall), .ReadDataW(a_rd), .ALUOutW(a_alu), .WA3W(a_wa3), .PCW(a_pc),
    .RegWriteW(a_rw), .MemtoRegW(a_mtr)
  );

  mem_stage_ws #(.ADDR_BITS(AB), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .ALUResultM(in_b.alu), .WriteDataM(in_b.wd), .WA3M(in_b.wa3), .PCM(in_b.pc),
    .RegWriteM(in_b.rw), .MemtoRegM(in_b.mtr), .MemWriteM(in_b.mw),
    .StallM(b_stall), .ReadDataW(b_rd), .ALUOutW(b_alu), .WA3W(b_wa3), .PCW(b_pc),
    .RegWriteW(b_rw), .MemtoRegW(b_mtr)
  );

  int sel;
  logic        o_stall, o_rw, o_mtr;
  logic [31:0] o_rd, o_alu, o_pc;
  logic [3:0]  o_wa3;

  always_comb begin
    o_stall = a_stall; o_rd = a_rd; o_alu = a_alu; o_pc = a_pc;
    o_wa3 = a_wa3; o_rw = a_rw; o_mtr = a_mtr;
    if (sel == 1) begin
      o_stall = b_stall; o_rd = b_rd; o_alu = b_alu; o_pc = b_pc;
      o_wa3 = b_wa3; o_rw = b_rw; o_mtr = b_mtr;
    end
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] mem   [2][DEPTH];
  bit          known [2][DEPTH];
  exp_t        ex    [2];
  int          wait_states [2] = '{2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_w(input string tag);
    if (ex[sel].rd_known) chk({tag, ".ReadDataW"}, o_rd, ex[sel].rd);
    chk({tag, ".ALUOutW"},   o_alu, ex[sel].alu);
    chk({tag, ".WA3W"},      {28'd0, o_wa3}, {28'd0, ex[sel].wa3});
    chk({tag, ".PCW"},       o_pc, ex[sel].pc);
    chk({tag, ".RegWriteW"}, {31'd0, o_rw}, {31'd0, ex[sel].rw});
    chk({tag, ".MemtoRegW"}, {31'd0, o_mtr}, {31'd0, ex[sel].mtr});
  endtask

  task automatic zero_exp(input int s);
    ex[s] = '{rd: '0, alu: '0, pc: '0, wa3: '0, rw: 1'b0, mtr: 1'b0, rd_known: 1'b1};
  endtask

  // Called just after a rising edge; returns just after the completion edge.
  task automatic run_op(input int s, input op_t op, input string tag);
    int w;
    int nstall;
    bit memop;
    sel = s;
    if (s == 0) begin in_a = op; in_b = '0; zero_exp(1); end
    else        begin in_b = op; in_a = '0; zero_exp(0); end
    memop  = op.mtr | op.mw;
    nstall = memop ? wait_states[s] : 0;
    w      = int'(op.alu[AB+1:2]);
    for (int k = 0; k < nstall; k++) begin
      @(negedge clk);
      chk({tag, ".stall_hi"}, {31'd0, o_stall}, 32'd1);
      @(posedge clk); #1;
      ex[s].rw  = 1'b0;
      ex[s].mtr = 1'b0;
      chk_w({tag, ".bubble"});
    end
    @(negedge clk);
    chk({tag, ".stall_lo"}, {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    ex[s].alu = op.alu;
    ex[s].wa3 = op.wa3;
    ex[s].pc  = op.pc;
    ex[s].rw  = op.rw;
    ex[s].mtr = op.mtr & ~op.mw;
    if (op.mw) begin
      ex[s].rd_known = 1'b0;
      mem[s][w]   = op.wd;
      known[s][w] = 1'b1;
    end else if (op.mtr) begin
      ex[s].rd       = mem[s][w];
      ex[s].rd_known = known[s][w];
    end else begin
      ex[s].rd       = '0;
      ex[s].rd_known = 1'b1;
    end
    chk_w({tag, ".wb"});
  endtask

  function automatic op_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa3,
                             input logic rw, input logic mtr, input logic mw);
    op_t o;
    o.alu = alu; o.wd = wd; o.wa3 = wa3; o.pc = $urandom;
    o.rw = rw; o.mtr = mtr; o.mw = mw;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int kind;
    kind = $urandom_range(0, 3);
    o.alu = $urandom; o.wd = $urandom; o.pc = $urandom;
    o.wa3 = 4'($urandom);
    o.rw  = 1'($urandom);
    o.mtr = (kind == 1 || kind == 3);
    o.mw  = (kind == 2 || kind == 3);
    return o;
  endfunction

  initial begin
    sel = 0;
    in_a = '0; in_b = '0;
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      zero_exp(s);
      for (int i = 0; i < DEPTH; i++) known[s][i] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.stall", {31'd0, a_stall}, 32'd0);
    chk_w("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Non-memop passthrough
    run_op(0, mk(32'h1234, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0), "nonmem");

    // Store then load from the same word with low bits set
    run_op(0, mk(32'h10, 32'hDEADBEEF, 4'd1, 1'b0, 1'b0, 1'b1), "store10");
    run_op(0, mk(32'h12, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0), "load12");
    chk("load12.data", o_rd, 32'hDEADBEEF);

    // Store+load flags together behave as a store
    run_op(0, mk(32'h14, 32'hA5A5A5A5, 4'd6, 1'b1, 1'b1, 1'b1), "both");
    run_op(0, mk(32'h14, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0), "load14");

    // Address wrap modulo depth
    run_op(0, mk(32'h100, 32'h55, 4'd2, 1'b0, 1'b0, 1'b1), "store100");
    run_op(0, mk(32'h0, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0), "load0");
    chk("wrap.data", o_rd, 32'h55);

    // Reset during BUSY aborts the store
    run_op(0, mk(32'h20, 32'h1, 4'd8, 1'b0, 1'b0, 1'b1), "pre20");
    in_a = mk(32'h20, 32'h77, 4'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("abort.stall0", {31'd0, a_stall}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    zero_exp(0);
    chk("abort.stall_in_reset", {31'd0, a_stall}, 32'd0);
    chk_w("abort.reset");
    in_a = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    zero_exp(1);
    chk_w("abort.after");
    run_op(0, mk(32'h5678, 32'h0, 4'd10, 1'b1, 1'b0, 1'b0), "abort.idle");
    run_op(0, mk(32'h20, 32'h0, 4'd11, 1'b1, 1'b1, 1'b0), "load20");
    chk("abort.data", o_rd, 32'h1);

    // Fill the RAM, then random traffic on the 2-wait-state instance
    for (int i = 0; i < DEPTH; i++)
      run_op(0, mk(32'(i * 4), $urandom, 4'd0, 1'b0, 1'b0, 1'b1), "fill");
    for (int i = 0; i < 150; i++) run_op(0, rnd_op(), "rnd_ws2");

    // Zero wait states: alternating store/load on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom;
      run_op(1, mk(32'h8, d, 4'd1, 1'b0, 1'b0, 1'b1), "ws0.store");
      run_op(1, mk(32'h8, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0), "ws0.load");
      chk("ws0.data", o_rd, d);
    end
    for (int i = 0; i < DEPTH; i++)
      run_op(1, mk(32'(i * 4), $urandom, 4'd0, 1'b0, 1'b0, 1'b1), "fill0");
    for (int i = 0; i < 100; i++) run_op(1, rnd_op(), "rnd_ws0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
